// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between N_REQ byte producers, the arbiter and uart_tx.
// ARB_LOCK_EN adds the per-port req_lock inputs used to keep multi-byte packets contiguous.
interface uart_tx_arbiter_if #(
    parameter int N_REQ        = 4,
    parameter int PAYLOAD_BITS = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [N_REQ-1:0]              req_ready;
    logic                          tx_busy;
    logic                          tx_enable;
    logic [PAYLOAD_BITS-1:0]       tx_data;
    logic [ID_W-1:0]               grant_id;
    logic                          arb_busy;
`ifdef ARB_LOCK_EN
    logic [N_REQ-1:0]              req_lock;

    modport master (
        input  req_valid, req_data, req_lock, tx_busy,
        output req_ready, tx_enable, tx_data, grant_id, arb_busy
    );
    modport slave (
        output req_valid, req_data, req_lock, tx_busy,
        input  req_ready, tx_enable, tx_data, grant_id, arb_busy
    );
`else
    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_enable, tx_data, grant_id, arb_busy
    );
    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_enable, tx_data, grant_id, arb_busy
    );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ valid/ready byte producers.
// Define ARB_LOCK_EN to let a port hold the grant across bytes via req_lock.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic               clk,
    input  logic               arb_reset,
    uart_tx_arbiter_if.master  bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic                    tx_enable_q, tx_enable_d;
    logic [1:0]              timeout_q, timeout_d;

    logic [ID_W-1:0]         winner;
    logic [ID_W-1:0]         cand;
    logic                    winner_found;
    logic                    lock_hold;
    logic                    accept;

`ifdef ARB_LOCK_EN
    logic lock_q, lock_d;

    // The lock survives only while its owner keeps req_lock raised.
    always_comb begin
        lock_hold = lock_q && bus.req_lock[grant_id_q];
    end

    always_comb begin
        lock_d = lock_hold;
        if (accept) begin
            lock_d = 1'b0;
        end else if (state_q == WAIT_DONE && !bus.tx_busy) begin
            lock_d = bus.req_lock[grant_id_q];
        end
    end

    always_ff @(posedge clk or posedge arb_reset) begin
        if (arb_reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    always_comb begin
        lock_hold = 1'b0;
    end
`endif

    // Search starts just past the last winner, so the port served last ranks lowest.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        if (lock_hold) begin
            winner       = grant_id_q;
            winner_found = bus.req_valid[grant_id_q];
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                if (int'(last_grant_q) + i >= N_REQ) begin
                    cand = ID_W'(int'(last_grant_q) + i - N_REQ);
                end else begin
                    cand = ID_W'(int'(last_grant_q) + i);
                end
                if (!winner_found && bus.req_valid[cand]) begin
                    winner       = cand;
                    winner_found = 1'b1;
                end
            end
        end
    end

    assign accept = (state_q == IDLE) && !bus.tx_busy && winner_found && !arb_reset;

    assign bus.req_ready = accept ? (N_REQ'(1) << winner) : '0;
    assign bus.tx_enable = tx_enable_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.arb_busy  = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        tx_enable_d  = 1'b0;
        timeout_d    = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d    = bus.req_data[int'(winner) * PAYLOAD_BITS +: PAYLOAD_BITS];
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    tx_enable_d  = 1'b1;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                timeout_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Four cycles without busy means uart_tx never took the byte; drop it.
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timeout_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    timeout_d = timeout_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arb_reset) begin
        if (arb_reset) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= LAST_ID;
            tx_enable_q  <= 1'b0;
            timeout_q    <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            tx_enable_q  <= tx_enable_d;
            timeout_q    <= timeout_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: arbitration vector table, scoreboarded uart_tx model,
// and sequences for busy-in-IDLE, uart timeout, mid-frame reset and (ARB_LOCK_EN) locked packets.
module tb_uart_tx_arbiter;
    localparam int N_REQ = 4;
    localparam int PB    = 8;
    localparam int FRAME = 10;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       busy;
        logic [3:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic arb_reset;
    logic force_busy;
    logic model_busy;
    logic uart_responds;
    int   frame_cnt;
    int   errors = 0;
    int   checks = 0;
    int   launch_count = 0;
    logic [7:0] last_data = '0;
    exp_t sb[$];
    exp_t e;
    vec_t vecs[$];

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .PAYLOAD_BITS(PB)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .PAYLOAD_BITS(PB)) dut (
        .clk       (clk),
        .arb_reset (arb_reset),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.tx_busy = model_busy | force_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx stand-in: takes the strobe, then stays busy for FRAME cycles.
    always @(posedge clk or posedge arb_reset) begin
        if (arb_reset) begin
            model_busy <= 1'b0;
            frame_cnt  <= 0;
        end else if (frame_cnt != 0) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1) model_busy <= 1'b0;
        end else if (bus.tx_enable && uart_responds) begin
            model_busy <= 1'b1;
            frame_cnt  <= FRAME;
        end
    end

    // Scoreboard side: every strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (!arb_reset) begin
            if (bus.tx_enable) begin
                launch_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got data %0h id %0d expected no launch",
                             bus.tx_data, bus.grant_id);
                end else begin
                    e = sb.pop_front();
                    check("launch tx_data", 32'(bus.tx_data), 32'(e.data));
                    check("launch grant_id", 32'(bus.grant_id), 32'(e.id));
                    last_data = e.data;
                end
            end else if (bus.arb_busy) begin
                check("tx_data stable", 32'(bus.tx_data), 32'(last_data));
            end
        end
    end

    task automatic set_data(input int port, input logic [7:0] d);
        bus.req_data[port*PB +: PB] = d;
    endtask

    task automatic wait_launches(input int target, input int budget);
        int n = 0;
        while (launch_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("launch count", 32'(launch_count), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.arb_busy || bus.tx_busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("return to idle", {30'd0, bus.arb_busy, bus.tx_busy}, 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        arb_reset = 1'b1;
        #2;
        arb_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        arb_reset     = 1'b1;
        force_busy    = 1'b0;
        uart_responds = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
`ifdef ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        #12;
        check("reset tx_enable", 32'(bus.tx_enable), 32'd0);
        check("reset arb_busy", 32'(bus.arb_busy), 32'd0);
        check("reset grant_id", 32'(bus.grant_id), 32'd0);
        check("reset tx_data", 32'(bus.tx_data), 32'd0);
        arb_reset = 1'b0;

        // Arbitration from reset: last_grant is port 3, so the search starts at port 0.
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 4'b1110, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 4'b1100, 1'b0, 4'b0100});
        vecs.push_back('{1'b0, 4'b1000, 1'b0, 4'b1000});
        vecs.push_back('{1'b0, 4'b1010, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 4'b0000});
        vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000});
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            arb_reset     = vecs[i].rst;
            bus.req_valid = vecs[i].valid;
            force_busy    = vecs[i].busy;
            #1;
            check($sformatf("table[%0d] req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            #1;
            bus.req_valid = '0;
            force_busy    = 1'b0;
            arb_reset     = 1'b0;
        end

        // Single byte from port 0 right after reset.
        reset_dut();
        @(negedge clk);
        set_data(0, 8'h55);
        bus.req_valid = 4'b0001;
        sb.push_back('{8'h55, 2'd0});
        #1;
        check("t1 req_ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        #1;
        check("t1 tx_enable", 32'(bus.tx_enable), 32'd1);
        check("t1 tx_data", 32'(bus.tx_data), 32'h55);
        check("t1 grant_id", 32'(bus.grant_id), 32'd0);
        check("t1 ready after accept", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        check("t1 strobe one cycle", 32'(bus.tx_enable), 32'd0);
        wait_idle(40);

        // All four ports held valid: strict rotation A0, A1, A2, A3, A0.
        reset_dut();
        @(negedge clk);
        base = launch_count;
        for (int p = 0; p < N_REQ; p++) set_data(p, 8'hA0 + 8'(p));
        for (int k = 0; k < 5; k++) sb.push_back('{8'hA0 + 8'(k % 4), 2'(k % 4)});
        bus.req_valid = 4'b1111;
        wait_launches(base + 5, 5 * (FRAME + 10));
        bus.req_valid = '0;
        wait_idle(40);

        // tx_busy high while IDLE blocks every grant until it falls.
        @(negedge clk);
        base = launch_count;
        force_busy = 1'b1;
        set_data(2, 8'h3C);
        bus.req_valid = 4'b0100;
        sb.push_back('{8'h3C, 2'd2});
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3 ready while busy", 32'(bus.req_ready), 32'd0);
            check("t3 idle while busy", 32'(bus.arb_busy), 32'd0);
            @(negedge clk);
        end
        force_busy = 1'b0;
        #1;
        check("t3 ready after busy", 32'(bus.req_ready), 32'b0100);
        wait_launches(base + 1, 10);
        bus.req_valid = '0;
        wait_idle(40);

        // uart_tx never answers: byte dropped after four WAIT_BUSY cycles.
        @(negedge clk);
        base = launch_count;
        uart_responds = 1'b0;
        set_data(1, 8'h11);
        bus.req_valid = 4'b0010;
        sb.push_back('{8'h11, 2'd1});
        wait_launches(base + 1, 10);
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("t4 busy cycle %0d", k), 32'(bus.arb_busy), 32'd1);
        end
        @(negedge clk);
        #1;
        check("t4 timeout to idle", 32'(bus.arb_busy), 32'd0);
        uart_responds = 1'b1;
        set_data(3, 8'h33);
        bus.req_valid = 4'b1000;
        sb.push_back('{8'h33, 2'd3});
        wait_launches(base + 2, 10);
        bus.req_valid = '0;
        wait_idle(40);

        // Reset during WAIT_DONE: outputs fall at once and port 0 regains priority.
        @(negedge clk);
        base = launch_count;
        set_data(2, 8'h77);
        bus.req_valid = 4'b0100;
        sb.push_back('{8'h77, 2'd2});
        wait_launches(base + 1, 10);
        bus.req_valid = '0;
        n = 0;
        while (!bus.tx_busy && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        check("t5 in WAIT_DONE", {30'd0, bus.arb_busy, bus.tx_busy}, 32'd3);
        bus.req_valid = 4'b1111;
        arb_reset = 1'b1;
        #1;
        check("t5 tx_enable in reset", 32'(bus.tx_enable), 32'd0);
        check("t5 arb_busy in reset", 32'(bus.arb_busy), 32'd0);
        check("t5 ready in reset", 32'(bus.req_ready), 32'd0);
        check("t5 grant_id in reset", 32'(bus.grant_id), 32'd0);
        check("t5 tx_data in reset", 32'(bus.tx_data), 32'd0);
        arb_reset = 1'b0;
        #1;
        check("t5 port0 priority", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        wait_idle(10);

`ifdef ARB_LOCK_EN
        // Locked packet of three bytes from port 1 goes before waiting port 3.
        reset_dut();
        @(negedge clk);
        base = launch_count;
        set_data(1, 8'hB0);
        set_data(3, 8'hD3);
        bus.req_lock  = 4'b0010;
        bus.req_valid = 4'b1010;
        sb.push_back('{8'hB0, 2'd1});
        sb.push_back('{8'hB1, 2'd1});
        sb.push_back('{8'hB2, 2'd1});
        sb.push_back('{8'hD3, 2'd3});
        wait_launches(base + 1, FRAME + 10);
        set_data(1, 8'hB1);
        wait_launches(base + 2, FRAME + 10);
        set_data(1, 8'hB2);
        wait_launches(base + 3, FRAME + 10);
        bus.req_lock     = '0;
        bus.req_valid[1] = 1'b0;
        wait_launches(base + 4, FRAME + 10);
        bus.req_valid = '0;
        wait_idle(40);
`endif

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
